// File: rtl/accum_seq_ctrl.sv
// Sequential accumulator/controller feeding a W-bit ripple add/sub stage.
// Optional saturation on signed overflow is compiled in with ACCUM_SAT_EN.
module accum_seq_ctrl #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [W-1:0] operand,
    output logic [W-1:0] as_A,
    output logic [W-1:0] as_B,
    output logic         as_c0,
    input  logic [W-1:0] as_S,
    input  logic         as_ovf,
    output logic [W-1:0] acc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         ovf_flag,
    output logic         ovf_sticky,
    output logic [1:0]   dbg_state
);

    localparam logic [1:0] OP_CLR  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    // Handshakes: a command transfers on a rising edge with in_valid & in_ready;
    // a result transfers on a rising edge with out_valid & out_ready. Neither
    // valid depends combinationally on its ready.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic [W-1:0] opnd_q, opnd_d;
    logic [W-1:0] acc_q, acc_d;
    logic         flag_q, flag_d;
    logic         sticky_q, sticky_d;

`ifdef ACCUM_SAT_EN
    localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_CLR;
            opnd_q   <= '0;
            acc_q    <= '0;
            flag_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            flag_q   <= flag_d;
            sticky_q <= sticky_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        flag_d   = flag_q;
        sticky_d = sticky_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    opnd_d  = operand;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
                case (op_q)
                    OP_CLR: begin
                        acc_d    = '0;
                        flag_d   = 1'b0;
                        sticky_d = 1'b0;
                    end
                    OP_LOAD: begin
                        acc_d    = opnd_q;
                        flag_d   = 1'b0;
                        sticky_d = 1'b0;
                    end
                    default: begin
                        // ADD and SUB differ only in as_c0; the add/sub does the rest.
`ifdef ACCUM_SAT_EN
                        if (as_ovf) acc_d = acc_q[W-1] ? SAT_NEG : SAT_POS;
                        else        acc_d = as_S;
`else
                        acc_d = as_S;
`endif
                        flag_d   = as_ovf;
                        sticky_d = sticky_q | as_ovf;
                    end
                endcase
            end
            RESP: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == RESP);
    assign as_A       = acc_q;
    assign as_B       = opnd_q;
    assign as_c0      = (op_q == OP_SUB);
    assign acc        = acc_q;
    assign ovf_flag   = flag_q;
    assign ovf_sticky = sticky_q;
    assign dbg_state  = state_q;

endmodule
